// File: rtl/ps2_kbd_pkg.sv
// Shared types, scan-code constants and the set-2 scan-to-ASCII lookup.
package ps2_kbd_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } prefix_state_t;

   localparam logic [BYTE_W-1:0] SC_EXT    = 8'hE0;
   localparam logic [BYTE_W-1:0] SC_BRK    = 8'hF0;
   localparam logic [BYTE_W-1:0] SC_LSHIFT = 8'h12;
   localparam logic [BYTE_W-1:0] SC_RSHIFT = 8'h59;
   localparam logic [BYTE_W-1:0] SC_CAPS   = 8'h58;
   localparam logic [BYTE_W-1:0] SC_UP     = 8'h75;
   localparam logic [BYTE_W-1:0] SC_DOWN   = 8'h72;
   localparam logic [BYTE_W-1:0] SC_LEFT   = 8'h6B;
   localparam logic [BYTE_W-1:0] SC_RIGHT  = 8'h74;

   // One FIFO entry: extended flag plus ASCII or raw scan code.
   typedef struct packed {
      logic              ext;
      logic [BYTE_W-1:0] data;
   } key_entry_t;

   typedef struct packed {
      logic              valid;
      logic [BYTE_W-1:0] ascii;
   } ascii_lookup_t;

   // Map a non-extended make code to ASCII; upper selects the letter case.
   function automatic ascii_lookup_t scan_to_ascii(input logic [BYTE_W-1:0] sc,
                                                   input logic upper);
      ascii_lookup_t r;
      logic          letter;
      logic [4:0]    idx;
      r.valid = 1'b1;
      r.ascii = 8'h00;
      letter  = 1'b1;
      idx     = 5'd0;
      case (sc)
         8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
         8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
         8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
         8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
         8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
         8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
         8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
         8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
         8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
         default: letter = 1'b0;
      endcase
      if (letter) begin
         r.ascii = (upper ? 8'h41 : 8'h61) + 8'(idx);
      end else begin
         case (sc)
            8'h45: r.ascii = 8'h30;  8'h16: r.ascii = 8'h31;
            8'h1E: r.ascii = 8'h32;  8'h26: r.ascii = 8'h33;
            8'h25: r.ascii = 8'h34;  8'h2E: r.ascii = 8'h35;
            8'h36: r.ascii = 8'h36;  8'h3D: r.ascii = 8'h37;
            8'h3E: r.ascii = 8'h38;  8'h46: r.ascii = 8'h39;
            8'h29: r.ascii = 8'h20;  8'h5A: r.ascii = 8'h0D;
            8'h66: r.ascii = 8'h08;  8'h76: r.ascii = 8'h1B;
            default: r.valid = 1'b0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// First-word-fall-through key FIFO with occupancy count.
module ps2_key_fifo
   import ps2_kbd_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  key_entry_t       wr_data,
   input  logic             rd_en,
   output key_entry_t       rd_data,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);

   key_entry_t        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = rd_en & ~empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = wr_en & (~full | do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// Decodes PS/2 set-2 scan bytes into ASCII / arrow-key entries queued in a FIFO.
module ps2_keycode_decoder
   import ps2_kbd_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_done_tick,
   input  logic [BYTE_W-1:0] dout,
   output logic              rx_en,
   input  logic              rd_en,
   output logic [BYTE_W-1:0] key_data,
   output logic              key_ext,
   output logic              key_empty,
   output logic              overflow,
   output logic              caps_on
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   prefix_state_t    state;
   logic             shift;
   logic             push_c;
   key_entry_t       push_entry_c;
   key_entry_t       head;
   logic             fifo_full;
   logic [CNT_W-1:0] fifo_count;
   ascii_lookup_t    lookup_c;
   logic             is_prefix_c;
   logic             is_shift_c;
   logic             is_modifier_c;
   logic             is_arrow_c;

   assign is_prefix_c   = (dout == SC_EXT) || (dout == SC_BRK);
   assign is_shift_c    = (dout == SC_LSHIFT) || (dout == SC_RSHIFT);
   assign is_modifier_c = is_shift_c || (dout == SC_CAPS);
   assign is_arrow_c    = (dout == SC_UP) || (dout == SC_DOWN) ||
                          (dout == SC_LEFT) || (dout == SC_RIGHT);
   assign lookup_c      = scan_to_ascii(dout, shift ^ caps_on);

   // Decide whether the current byte completes a key that must be queued.
   always_comb begin
      push_c       = 1'b0;
      push_entry_c = '0;
      if (rx_done_tick && !is_prefix_c) begin
         case (state)
            ST_IDLE: begin
               if (!is_modifier_c && lookup_c.valid) begin
                  push_c       = 1'b1;
                  push_entry_c = '{ext: 1'b0, data: lookup_c.ascii};
               end
            end
            ST_EXT: begin
               if (is_arrow_c) begin
                  push_c       = 1'b1;
                  push_entry_c = '{ext: 1'b1, data: dout};
               end
            end
            default: ;
         endcase
      end
   end

   // Prefix FSM plus shift / caps-lock / sticky overflow tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         shift    <= 1'b0;
         caps_on  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (push_c && fifo_full && !rd_en) begin
            overflow <= 1'b1;
         end
         if (rx_done_tick) begin
            case (state)
               ST_IDLE: begin
                  if (dout == SC_EXT)      state <= ST_EXT;
                  else if (dout == SC_BRK) state <= ST_BRK;
                  else if (is_shift_c)     shift <= 1'b1;
                  else if (dout == SC_CAPS) caps_on <= ~caps_on;
               end
               ST_EXT: begin
                  if (dout == SC_BRK)      state <= ST_EXT_BRK;
                  else if (dout != SC_EXT) state <= ST_IDLE;
               end
               ST_BRK: begin
                  if (dout != SC_BRK) begin
                     if (is_shift_c) shift <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
               ST_EXT_BRK: begin
                  if (!is_prefix_c) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   ps2_key_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_c),
      .wr_data (push_entry_c),
      .rd_en   (rd_en),
      .rd_data (head),
      .empty   (key_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign key_data = head.data;
   assign key_ext  = head.ext;
   // Keep one slot free for a frame already in flight when the receiver is stopped.
   assign rx_en    = (fifo_count <= CNT_W'(DEPTH - 2));

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed bench for ps2_keycode_decoder with an expected-entry scoreboard.
module tb_ps2_keycode_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_done_tick = 1'b0;
   logic [7:0] dout = 8'h00;
   logic       rx_en;
   logic       rd_en = 1'b0;
   logic [7:0] key_data;
   logic       key_ext;
   logic       key_empty;
   logic       overflow;
   logic       caps_on;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;
   logic [8:0]  exp_q [$];

   always #5 clk = ~clk;

   ps2_keycode_decoder #(.DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .dout         (dout),
      .rx_en        (rx_en),
      .rd_en        (rd_en),
      .key_data     (key_data),
      .key_ext      (key_ext),
      .key_empty    (key_empty),
      .overflow     (overflow),
      .caps_on      (caps_on)
   );

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All stimulus tasks start and end on a falling edge.
   task automatic send(input logic [7:0] b, input logic pop = 1'b0);
      dout = b;
      rx_done_tick = 1'b1;
      rd_en = pop;
      @(negedge clk);
      rx_done_tick = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic drain(input string tag);
      logic [8:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "/nonempty"}, 9'(key_empty), 9'd0);
         check({tag, "/entry"}, {key_ext, key_data}, e);
         pop_one();
      end
      check({tag, "/drained"}, 9'(key_empty), 9'd1);
   endtask

   // Reset held two cycles with a tick present to show it is ignored.
   task automatic do_reset();
      reset = 1'b1;
      rx_done_tick = 1'b1;
      dout = 8'h1C;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      rx_done_tick = 1'b0;
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      do_reset();
      check("rst/empty", 9'(key_empty), 9'd1);
      check("rst/data", {key_ext, key_data}, 9'h000);
      check("rst/rx_en", 9'(rx_en), 9'd1);
      check("rst/ovf", 9'(overflow), 9'd0);
      check("rst/caps", 9'(caps_on), 9'd0);

      // Plain make, break discarded, typematic repeats.
      send(8'h1C); exp_q.push_back(9'h061);
      check("lat/nonempty", 9'(key_empty), 9'd0);
      send(8'hF0); send(8'h1C);
      send(8'h1C); exp_q.push_back(9'h061);
      send(8'h1C); exp_q.push_back(9'h061);
      drain("make");

      // Shift and caps lock.
      send(8'h12); send(8'h1C); exp_q.push_back(9'h041);
      send(8'hF0); send(8'h12);
      send(8'h1C); exp_q.push_back(9'h061);
      drain("shift");
      send(8'h58);
      check("caps/on", 9'(caps_on), 9'd1);
      send(8'h1C); exp_q.push_back(9'h041);
      send(8'hF0); send(8'h58);
      check("caps/brk", 9'(caps_on), 9'd1);
      send(8'h12); send(8'h1C); exp_q.push_back(9'h061);
      send(8'hF0); send(8'h12);
      drain("caps");
      send(8'h12); send(8'h16); exp_q.push_back(9'h031);
      send(8'hF0); send(8'h12);
      send(8'h29); exp_q.push_back(9'h020);
      send(8'h5A); exp_q.push_back(9'h00D);
      send(8'h66); exp_q.push_back(9'h008);
      drain("ctrl");
      send(8'h76); exp_q.push_back(9'h01B);
      send(8'h58);
      check("caps/off", 9'(caps_on), 9'd0);
      send(8'h1C); exp_q.push_back(9'h061);
      drain("esc");

      // Extended keys.
      send(8'hE0); send(8'h75); exp_q.push_back(9'h175);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hE0); send(8'h72); exp_q.push_back(9'h172);
      send(8'hE0); send(8'h6B); exp_q.push_back(9'h16B);
      send(8'hE0); send(8'h74); exp_q.push_back(9'h174);
      drain("ext");
      send(8'hE0); send(8'h1C);
      send(8'hE0); send(8'hE0); send(8'h75); exp_q.push_back(9'h175);
      send(8'hF0); send(8'hE0); send(8'h1C); exp_q.push_back(9'h061);
      send(8'hE0); send(8'hF0); send(8'hE0); send(8'hF0); send(8'h75);
      drain("prefix");

      // Fill past capacity.
      send(8'h16); exp_q.push_back(9'h031);
      check("fill1/rx_en", 9'(rx_en), 9'd1);
      send(8'h16); exp_q.push_back(9'h031);
      check("fill2/rx_en", 9'(rx_en), 9'd1);
      send(8'h16); exp_q.push_back(9'h031);
      check("fill3/rx_en", 9'(rx_en), 9'd0);
      send(8'h16); exp_q.push_back(9'h031);
      check("fill4/ovf", 9'(overflow), 9'd0);
      send(8'h16);
      check("fill5/ovf", 9'(overflow), 9'd1);
      check("pop/head", {key_ext, key_data}, exp_q.pop_front());
      pop_one();
      check("pop/rx_en", 9'(rx_en), 9'd0);
      drain("ovf");
      check("ovf/sticky", 9'(overflow), 9'd1);

      // Reset in the middle of a prefix and with shift held.
      send(8'hF0);
      do_reset();
      check("mid/ovf", 9'(overflow), 9'd0);
      send(8'h1C); exp_q.push_back(9'h061);
      drain("midbrk");
      send(8'h12);
      do_reset();
      send(8'h1C); exp_q.push_back(9'h061);
      drain("midshift");
      send(8'h05);
      check("unmapped/empty", 9'(key_empty), 9'd1);

      // Push coinciding with a pop on a full FIFO.
      repeat (4) begin
         send(8'h1C); exp_q.push_back(9'h061);
      end
      check("full/rx_en", 9'(rx_en), 9'd0);
      check("full/head", {key_ext, key_data}, exp_q.pop_front());
      send(8'h16, 1'b1); exp_q.push_back(9'h031);
      check("full/ovf", 9'(overflow), 9'd0);
      check("full/rx_en2", 9'(rx_en), 9'd0);
      drain("fullpp");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
